// File: rtl/vcxo_pll_ctrl.sv
// vcxo_pll_ctrl -- frequency-locking controller for a VCXO disciplined by a TCXO.
//
// A gate of GATE_TICKS TCXO rising edges is opened, and the VCXO rising edges
// seen during it are counted. The count is compared with VCXO_NOMINAL, offset
// by correction_in, and the resulting error trims the duty cycle of a PWM
// whose filtered output tunes the VCXO. A trim is applied only when two
// consecutive measurements agree, which rejects counts corrupted by
// gate-boundary jitter.
//
// Ports
//   clk_in        system clock (faster than 2x either reference)
//   reset_in      asynchronous active-high reset
//   vcxo_in       VCXO signal, asynchronous to clk_in
//   tcxo_in       TCXO reference, asynchronous to clk_in
//   correction_in signed offset added to every measured error
//   hold_in       TX hold: abandons the gate and freezes tuning
//   freq_error    last error that was acted on (0 once inside FINE_BAND)
//   pwm_level     current PWM duty setting, 1..PWM_MAX
//   pump          registered PWM output
//   meas_valid    one-cycle pulse per completed measurement
//   locked        LOCK_COUNT consecutive in-band tuned measurements seen
module vcxo_pll_ctrl #(
  parameter int GATE_TICKS   = 1228800,
  parameter int VCXO_NOMINAL = 12288000,
  parameter int CNT_W        = 32,
  parameter int PWM_W        = 16,
  parameter int PWM_MAX      = 32000,
  parameter int PWM_INIT     = 16000,
  parameter int COARSE_BAND  = 10,
  parameter int FINE_BAND    = 1,
  parameter int COARSE_SHIFT = 1,
  parameter int LOCK_COUNT   = 4
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    vcxo_in,
  input  logic                    tcxo_in,
  input  logic signed [15:0]      correction_in,
  input  logic                    hold_in,
  output logic signed [CNT_W-1:0] freq_error,
  output logic [PWM_W-1:0]        pwm_level,
  output logic                    pump,
  output logic                    meas_valid,
  output logic                    locked
);

  localparam int ADJ_W  = CNT_W + 2;
  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]        GATE_LAST = CNT_W'(GATE_TICKS - 1);
  localparam logic [CNT_W-1:0]        NOMINAL   = CNT_W'(VCXO_NOMINAL);
  localparam logic [CNT_W:0]          COARSE_B  = (CNT_W + 1)'(COARSE_BAND);
  localparam logic [CNT_W:0]          FINE_B    = (CNT_W + 1)'(FINE_BAND);
  localparam logic [PWM_W-1:0]        PWM_LAST  = PWM_W'(PWM_MAX - 1);
  localparam logic signed [ADJ_W-1:0] ADJ_MAX   = ADJ_W'(PWM_MAX);
  localparam logic signed [ADJ_W-1:0] ADJ_MIN   = ADJ_W'(1);
  localparam logic [LOCK_W-1:0]       LOCK_FULL = LOCK_W'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, GATE, CALC, TUNE} state_t;

  state_t state, state_next;

  logic [2:0]               vcxo_sync, tcxo_sync;
  logic                     vcxo_edge, tcxo_edge, gate_done;
  logic [CNT_W-1:0]         tcxo_cnt, vcxo_cnt, vcxo_inc, vcxo_lat;
  logic signed [CNT_W-1:0]  err_now, err_prev;
  logic                     prev_valid;
  logic [LOCK_W-1:0]        lock_cnt;
  logic [PWM_W-1:0]         pwm_cnt;
  logic [CNT_W:0]           err_abs;
  logic                     err_coarse, err_fine;
  logic signed [ADJ_W-1:0]  err_ext, pwm_sum;
  logic [PWM_W-1:0]         pwm_clamped;

  // Bits [1:0] resynchronise; bit 2 holds the previous synchronised level.
  assign vcxo_edge = vcxo_sync[1] & ~vcxo_sync[2];
  assign tcxo_edge = tcxo_sync[1] & ~tcxo_sync[2];
  assign gate_done = tcxo_edge && (tcxo_cnt == GATE_LAST);

  // Saturating VCXO count, also used as the latched value so an edge landing
  // on the closing TCXO edge is not lost.
  assign vcxo_inc = (vcxo_edge && (vcxo_cnt != '1)) ? vcxo_cnt + 1'b1 : vcxo_cnt;

  // Magnitude is one bit wider so the most negative error cannot overflow.
  assign err_abs    = err_now[CNT_W-1] ? -{err_now[CNT_W-1], err_now} : {1'b0, err_now};
  assign err_coarse = err_abs > COARSE_B;
  assign err_fine   = err_abs <= FINE_B;
  assign err_ext    = ADJ_W'(err_now);

  always_comb begin
    pwm_sum = $signed({{(ADJ_W - PWM_W){1'b0}}, pwm_level})
            - (err_coarse ? (err_ext <<< COARSE_SHIFT) : err_ext);
    if (pwm_sum > ADJ_MAX) begin
      pwm_clamped = PWM_W'(ADJ_MAX);
    end else if (pwm_sum < ADJ_MIN) begin
      pwm_clamped = PWM_W'(ADJ_MIN);
    end else begin
      pwm_clamped = PWM_W'(pwm_sum);
    end
  end

  assign locked = (lock_cnt == LOCK_FULL);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next is assigned before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    if (hold_in) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: state_next = GATE;
        GATE: if (gate_done) state_next = CALC;
        CALC: state_next = TUNE;
        TUNE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: every register here uses <= so all of them sample the values from
  // before this edge; a blocking = would let later lines see updated values.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      vcxo_sync  <= '0;
      tcxo_sync  <= '0;
      tcxo_cnt   <= '0;
      vcxo_cnt   <= '0;
      vcxo_lat   <= '0;
      err_now    <= '0;
      err_prev   <= '0;
      prev_valid <= 1'b0;
      lock_cnt   <= '0;
      freq_error <= '0;
      pwm_level  <= PWM_W'(PWM_INIT);
      pwm_cnt    <= '0;
      pump       <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      vcxo_sync  <= {vcxo_sync[1:0], vcxo_in};
      tcxo_sync  <= {tcxo_sync[1:0], tcxo_in};
      pwm_cnt    <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      pump       <= (pwm_cnt < pwm_level);
      meas_valid <= 1'b0;

      if (hold_in) begin
        // pwm_level and freq_error deliberately keep their values.
        tcxo_cnt   <= '0;
        vcxo_cnt   <= '0;
        prev_valid <= 1'b0;
        lock_cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            tcxo_cnt <= '0;
            vcxo_cnt <= '0;
          end
          GATE: begin
            tcxo_cnt <= tcxo_cnt + CNT_W'(tcxo_edge);
            vcxo_cnt <= vcxo_inc;
            if (gate_done) vcxo_lat <= vcxo_inc;
          end
          CALC: begin
            err_now <= $signed(vcxo_lat - NOMINAL + CNT_W'(correction_in));
          end
          TUNE: begin
            meas_valid <= 1'b1;
            err_prev   <= err_now;
            prev_valid <= 1'b1;
            if (prev_valid && (err_now == err_prev)) begin
              if (err_fine) begin
                freq_error <= '0;
                if (lock_cnt != LOCK_FULL) lock_cnt <= lock_cnt + 1'b1;
              end else begin
                pwm_level  <= pwm_clamped;
                freq_error <= err_now;
                lock_cnt   <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vcxo_pll_ctrl.sv
// tb_vcxo_pll_ctrl -- self-checking bench for vcxo_pll_ctrl with a short gate
// (GATE_TICKS=10, VCXO_NOMINAL=100). Each gate is generated as an exact number
// of VCXO pulses randomly interleaved with TCXO pulses, the tenth TCXO pulse
// always last, so the expected count is known. A measurement-level model
// (error, agreement, banding, clamp, lock run) predicts the outputs at each
// meas_valid.
module tb_vcxo_pll_ctrl;

  localparam int GATE_TICKS = 10;
  localparam int NOMINAL    = 100;
  localparam int PWM_MAX    = 32000;
  localparam int PWM_INIT   = 16000;

  logic               clk_in = 1'b0;
  logic               reset_in = 1'b1;
  logic               vcxo_in = 1'b0;
  logic               tcxo_in = 1'b0;
  logic signed [15:0] correction_in = '0;
  logic               hold_in = 1'b0;
  logic signed [31:0] freq_error;
  logic [15:0]        pwm_level;
  logic               pump;
  logic               meas_valid;
  logic               locked;

  int n_checks = 0;
  int n_fail   = 0;

  // Measurement-level reference state.
  int m_pwm, m_ferr, m_lock, m_prev;
  bit m_pv;

  vcxo_pll_ctrl #(
    .GATE_TICKS  (GATE_TICKS),
    .VCXO_NOMINAL(NOMINAL)
  ) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .vcxo_in      (vcxo_in),
    .tcxo_in      (tcxo_in),
    .correction_in(correction_in),
    .hold_in      (hold_in),
    .freq_error   (freq_error),
    .pwm_level    (pwm_level),
    .pump         (pump),
    .meas_valid   (meas_valid),
    .locked       (locked)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pwm  = PWM_INIT;
    m_ferr = 0;
    m_lock = 0;
    m_prev = 0;
    m_pv   = 1'b0;
  endtask

  task automatic model_gate(input int n, input int corr);
    int err, mag;
    err = n - NOMINAL + corr;
    if (m_pv && err == m_prev) begin
      mag = (err < 0) ? -err : err;
      if (mag > 10) begin
        m_pwm  = m_pwm - 2 * err;
        m_ferr = err;
        m_lock = 0;
      end else if (mag > 1) begin
        m_pwm  = m_pwm - err;
        m_ferr = err;
        m_lock = 0;
      end else begin
        m_ferr = 0;
        if (m_lock < 4) m_lock++;
      end
      if (m_pwm > PWM_MAX) m_pwm = PWM_MAX;
      if (m_pwm < 1) m_pwm = 1;
    end
    m_prev = err;
    m_pv   = 1'b1;
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    reset_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_in);
  endtask

  task automatic pulse(input bit is_tcxo);
    if (is_tcxo) tcxo_in = 1'b1; else vcxo_in = 1'b1;
    repeat (2) @(negedge clk_in);
    tcxo_in = 1'b0;
    vcxo_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  // nv VCXO pulses and nt TCXO pulses, randomly interleaved, last TCXO pulse last.
  task automatic drive_pulses(input int nv, input int nt);
    int v, t;
    v = nv;
    t = nt;
    while (v > 0 || t > 1) begin
      if (t > 1 && (v == 0 || $urandom_range(0, 7) == 0)) begin
        pulse(1'b1);
        t--;
      end else begin
        pulse(1'b0);
        v--;
      end
    end
    if (t == 1) pulse(1'b1);
  endtask

  task automatic run_gate(input string tag, input int n, input int corr);
    bit seen;
    seen = 1'b0;
    correction_in = 16'(corr);
    drive_pulses(n, GATE_TICKS);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in);
      if (meas_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_meas_valid_seen"}, 64'(seen), 64'(1));
    model_gate(n, corr);
    check({tag, "_pwm_level"}, pwm_level, m_pwm);
    check({tag, "_freq_error"}, freq_error, m_ferr);
    check({tag, "_locked"}, locked, (m_lock == 4) ? 1 : 0);
    @(negedge clk_in);
    check({tag, "_meas_valid_pulse_width"}, meas_valid, 0);
  endtask

  task automatic count_meas_valid(input int cycles, output int hits);
    hits = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk_in);
      if (meas_valid) hits++;
    end
  endtask

  initial begin
    int hi, lo, hits;
    model_reset();
    do_reset();

    // Reset state.
    check("reset_pwm_level", pwm_level, PWM_INIT);
    check("reset_freq_error", freq_error, 0);
    check("reset_meas_valid", meas_valid, 0);
    check("reset_locked", locked, 0);

    // One full PWM period at the initial duty.
    hi = 0;
    repeat (PWM_MAX) begin
      @(negedge clk_in);
      hi += int'(pump);
    end
    check("pump_duty_init", hi, PWM_INIT);

    // Two agreeing coarse measurements.
    run_gate("c120a", 120, 0);
    run_gate("c120b", 120, 0);
    check("c120_pwm_15960", pwm_level, 15960);

    // Fine step, disagreement, then in-band agreement.
    do_reset();
    run_gate("f105a", 105, 0);
    run_gate("f105b", 105, 0);
    check("f105_pwm_15995", pwm_level, 15995);
    run_gate("f101a", 101, 0);
    run_gate("f101b", 101, 0);

    // Lock acquisition and loss.
    do_reset();
    for (int g = 0; g < 5; g++) run_gate("lock0", 100, 0);
    check("lock_after_5", locked, 1);
    run_gate("unlock50a", 150, 0);
    run_gate("unlock50b", 150, 0);
    check("unlock_after_50x2", locked, 0);

    // Re-lock, then reset in the middle of a gate.
    for (int g = 0; g < 5; g++) run_gate("relock", 100, 0);
    drive_pulses(30, 4);
    #2 reset_in = 1'b1;
    #1;
    check("async_reset_pwm_level", pwm_level, PWM_INIT);
    check("async_reset_pump", pump, 0);
    check("async_reset_locked", locked, 0);
    check("async_reset_meas_valid", meas_valid, 0);
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
    model_reset();
    count_meas_valid(40, hits);
    check("reset_midgate_no_meas_valid", hits, 0);

    // Clamp at both ends.
    run_gate("clamp_hi_a", 100, -20000);
    run_gate("clamp_hi_b", 100, -20000);
    check("clamp_hi_pwm", pwm_level, PWM_MAX);
    run_gate("clamp_hi_c", 100, -20000);
    repeat (3) @(negedge clk_in);
    lo = 0;
    repeat (200) begin
      @(negedge clk_in);
      if (!pump) lo++;
    end
    check("clamp_hi_pump_always_1", lo, 0);
    run_gate("clamp_lo_a", 100, 20000);
    run_gate("clamp_lo_b", 100, 20000);
    check("clamp_lo_pwm", pwm_level, 1);

    // Hold mid-gate.
    do_reset();
    for (int g = 0; g < 5; g++) run_gate("prehold0", 100, 0);
    run_gate("prehold30", 130, 0);
    check("prehold_locked", locked, 1);
    drive_pulses(40, 5);
    repeat (6) @(negedge clk_in);
    hold_in = 1'b1;
    @(negedge clk_in);
    check("hold_locked_cleared", locked, 0);
    check("hold_pwm_held", pwm_level, m_pwm);
    @(negedge clk_in);
    hold_in = 1'b0;
    m_pv   = 1'b0;
    m_lock = 0;
    count_meas_valid(40, hits);
    check("hold_no_meas_valid", hits, 0);
    check("hold_freq_error_held", freq_error, m_ferr);
    run_gate("posthold30a", 130, 0);
    run_gate("posthold30b", 130, 0);

    // Randomised measurements, half of them repeating the previous one.
    begin
      int n, corr;
      n = 100;
      corr = 0;
      for (int g = 0; g < 16; g++) begin
        if ($urandom_range(0, 1) == 0) begin
          n    = 88 + int'($urandom_range(0, 24));
          corr = int'($urandom_range(0, 6)) - 3;
        end
        run_gate("rand", n, corr);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vcxo_pll_ctrl.md
VCXO_PLL_CTRL -- requirements
Module: vcxo_pll_ctrl

Interface
REQ-001 SHALL have parameter GATE_TICKS, default 1228800: TCXO rising edges per measurement gate.
REQ-002 SHALL have parameter VCXO_NOMINAL, default 12288000: expected VCXO rising edges per gate.
REQ-003 SHALL have parameter CNT_W, default 32: width of the counters and of freq_error.
REQ-004 SHALL have parameter PWM_W, default 16: width of the PWM counter and of pwm_level.
REQ-005 SHALL have parameter PWM_MAX, default 32000: PWM period in clk_in cycles and upper clamp.
REQ-006 SHALL have parameter PWM_INIT, default 16000: pwm_level after reset.
REQ-007 SHALL have parameter COARSE_BAND, default 10: |error| threshold for the coarse step.
REQ-008 SHALL have parameter FINE_BAND, default 1: |error| threshold for the fine step and for lock.
REQ-009 SHALL have parameter COARSE_SHIFT, default 1: left shift applied to the error in the coarse step.
REQ-010 SHALL have parameter LOCK_COUNT, default 4: consecutive in-band tuned measurements required for lock.
REQ-011 SHALL use one clock; reset is asynchronous and active-high.
REQ-012 SHALL have port clk_in, input, 1 bit: system clock; must exceed 2x both reference frequencies.
REQ-013 SHALL have port reset_in, input, 1 bit: asynchronous active-high reset.
REQ-014 SHALL have port vcxo_in, input, 1 bit: VCXO signal, asynchronous to clk_in.
REQ-015 SHALL have port tcxo_in, input, 1 bit: TCXO reference, asynchronous to clk_in.
REQ-016 SHALL have port correction_in, input, 16 bits signed: offset added to the error.
REQ-017 SHALL have port hold_in, input, 1 bit: TX hold; freezes tuning.
REQ-018 SHALL have port freq_error, output, CNT_W bits signed: last tuned error.
REQ-019 SHALL have port pwm_level, output, PWM_W bits: current duty setting.
REQ-020 SHALL have port pump, output, 1 bit: registered PWM output.
REQ-021 SHALL have port meas_valid, output, 1 bit: one-cycle pulse per completed measurement.
REQ-022 SHALL have port locked, output, 1 bit: lock indicator.

Function
REQ-023 SHALL synchronise vcxo_in and tcxo_in through 2 flops each and detect rising edges on a third flop; edge-to-count latency 3 clk_in cycles.
REQ-024 SHALL implement FSM IDLE->GATE->CALC->TUNE->IDLE; IDLE clears both edge counters and advances to GATE next cycle if hold_in=0.
REQ-025 In GATE, SHALL count TCXO and VCXO edges; when the TCXO count reaches GATE_TICKS, SHALL latch the VCXO count, including any VCXO edge in that same cycle, and go to CALC.
REQ-026 The VCXO counter SHALL saturate at all-ones, with no wrap.
REQ-027 CALC SHALL compute err_now = vcxo_count - VCXO_NOMINAL + sign-extended correction_in, signed CNT_W, then go to TUNE.
REQ-028 TUNE SHALL pulse meas_valid for 1 cycle, store err_prev=err_now, set prev_valid=1, and return to IDLE.
REQ-029 TUNE SHALL adjust only when prev_valid=1 and err_now==err_prev; otherwise pwm_level, freq_error and the lock counter are unchanged.
REQ-030 Adjust rule, case |err|>COARSE_BAND: pwm_level -= err<<<COARSE_SHIFT; freq_error=err.
REQ-031 Adjust rule, case FINE_BAND<|err|<=COARSE_BAND: pwm_level -= err; freq_error=err.
REQ-032 Adjust rule, case |err|<=FINE_BAND: pwm_level unchanged; freq_error=0.
REQ-033 The adjustment SHALL be computed at CNT_W+2 bits signed, then clamped to [1, PWM_MAX] before truncation to PWM_W.
REQ-034 Lock counter SHALL increment, saturating at LOCK_COUNT, on an adjusting TUNE with |err|<=FINE_BAND, and clear on an adjusting TUNE with |err|>FINE_BAND.
REQ-035 locked SHALL be 1 iff the lock counter equals LOCK_COUNT.
REQ-036 hold_in=1 in any state SHALL force IDLE next cycle, clear the counters, prev_valid, the lock counter and locked, and produce no meas_valid.
REQ-037 hold_in SHALL leave pwm_level and freq_error held, and the PWM SHALL keep running.
REQ-038 PWM counter SHALL run free 0..PWM_MAX-1 and wrap to 0; pump = (counter < pwm_level), registered one cycle; pwm_level=PWM_MAX gives pump constantly 1.

Reset
REQ-039 reset_in=1 SHALL immediately set pwm_level=PWM_INIT and pump=0.
REQ-040 reset_in=1 SHALL immediately set freq_error=0, meas_valid=0 and locked=0.
REQ-041 reset_in=1 SHALL immediately set state=IDLE, clear all counters, sync flops, err_prev and prev_valid.
REQ-042 First GATE SHALL start 1 cycle after reset_in deasserts, provided hold_in=0.
REQ-043 Reset mid-gate SHALL discard the partial measurement.

Verification (GATE_TICKS=10, VCXO_NOMINAL=100, defaults otherwise)
REQ-044 Assert reset_in mid-GATE -> pwm_level=16000, pump=0, locked=0 asynchronously; no meas_valid.
REQ-045 Two gates of 120 VCXO edges -> 1st meas_valid: no change; 2nd: pwm_level=15960, freq_error=+20.
REQ-046 Gates of 105, 105, 101 -> pwm_level 15995 after 2nd; 101 vs 105 mismatch, no change; repeat 101 -> freq_error=0, pwm unchanged.
REQ-047 Error 0 for 5 gates -> locked=1 at the 5th meas_valid; then error 50 twice -> locked=0.
REQ-048 Error -20000 repeated -> pwm_level clamps at 32000, pump stays 1; error +20000 -> clamps at 1.
REQ-049 hold_in pulsed mid-GATE -> no meas_valid, locked=0, pwm_level held; after release the first measurement makes no adjustment.
